mc_control_unit: RTL

Multi-cycle control unit for the LEGv8 datapath. It replaces the single-cycle opcode-to-control decoder with a state machine that sequences fetch, decode, execute, memory and write-back over several clocks. It handshakes with a variable-latency instruction/data memory, resolves B/CBZ/CBNZ with correct branch semantics, traps illegal opcodes and counts retired instructions.

---
 rtl/mc_cu_pkg.sv | 56 +++++
 rtl/mc_cu_decode.sv | 40 ++++
 rtl/mc_control_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mc_cu_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control unit: FSM states,
// instruction classes, opcode match patterns and datapath control codes.
package mc_cu_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd7;

    typedef enum logic [2:0] {
        CL_RTYPE   = 3'd0,
        CL_ITYPE   = 3'd1,
        CL_LDUR    = 3'd2,
        CL_STUR    = 3'd3,
        CL_B       = 3'd4,
        CL_CBZ     = 3'd5,
        CL_CBNZ    = 3'd6,
        CL_ILLEGAL = 3'd7
    } instrClass_t;

    // Full 11-bit opcodes
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // Immediate forms match on [10:1], compare-and-branch on [10:3], B on [10:5]
    localparam logic [9:0] OP_ADDI = 10'b1001000100;
    localparam logic [9:0] OP_SUBI = 10'b1101000100;
    localparam logic [9:0] OP_ANDI = 10'b1001001000;
    localparam logic [9:0] OP_ORRI = 10'b1011001000;
    localparam logic [7:0] OP_CBZ  = 8'b10110100;
    localparam logic [7:0] OP_CBNZ = 8'b10110101;
    localparam logic [5:0] OP_B    = 6'b000101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;

    localparam logic [1:0] SEU_I  = 2'b00;
    localparam logic [1:0] SEU_D  = 2'b01;
    localparam logic [1:0] SEU_B  = 2'b10;
    localparam logic [1:0] SEU_CB = 2'b11;

    typedef struct packed {
        instrClass_t iClass;
        logic [2:0]  aluOp;
    } decoded_t;

endpackage

// File: rtl/mc_cu_decode.sv
// Combinational opcode decoder: maps the instruction-register opcode to an
// instruction class plus its ALU operation, honouring the match-width priority.
module mc_cu_decode
    import mc_cu_pkg::*;
#(
    parameter int OPCODE_W = 11
) (
    input  logic [OPCODE_W-1:0] opcode,
    output decoded_t            dec
);

    logic [10:0] opFull;
    logic [9:0]  opImm;
    logic [7:0]  opCb;
    logic [5:0]  opBr;

    assign opFull = opcode[OPCODE_W-1 -: 11];
    assign opImm  = opcode[OPCODE_W-1 -: 10];
    assign opCb   = opcode[OPCODE_W-1 -: 8];
    assign opBr   = opcode[OPCODE_W-1 -: 6];

    // Longest match wins, so the full-width compares come first.
    always_comb begin
        dec = '{iClass: CL_ILLEGAL, aluOp: ALU_ADD};
        if (opFull == OP_ADD)       dec = '{iClass: CL_RTYPE, aluOp: ALU_ADD};
        else if (opFull == OP_SUB)  dec = '{iClass: CL_RTYPE, aluOp: ALU_SUB};
        else if (opFull == OP_AND)  dec = '{iClass: CL_RTYPE, aluOp: ALU_AND};
        else if (opFull == OP_ORR)  dec = '{iClass: CL_RTYPE, aluOp: ALU_ORR};
        else if (opFull == OP_LDUR) dec = '{iClass: CL_LDUR,  aluOp: ALU_ADD};
        else if (opFull == OP_STUR) dec = '{iClass: CL_STUR,  aluOp: ALU_ADD};
        else if (opImm == OP_ADDI)  dec = '{iClass: CL_ITYPE, aluOp: ALU_ADD};
        else if (opImm == OP_SUBI)  dec = '{iClass: CL_ITYPE, aluOp: ALU_SUB};
        else if (opImm == OP_ANDI)  dec = '{iClass: CL_ITYPE, aluOp: ALU_AND};
        else if (opImm == OP_ORRI)  dec = '{iClass: CL_ITYPE, aluOp: ALU_ORR};
        else if (opCb == OP_CBZ)    dec = '{iClass: CL_CBZ,   aluOp: ALU_PASSB};
        else if (opCb == OP_CBNZ)   dec = '{iClass: CL_CBNZ,  aluOp: ALU_PASSB};
        else if (opBr == OP_B)      dec = '{iClass: CL_B,     aluOp: ALU_ADD};
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle LEGv8 control unit: sequences fetch/decode/execute/memory/
// write-back, handshakes with variable-latency memory and counts retirements.
module mc_control_unit
    import mc_cu_pkg::*;
#(
    parameter int OPCODE_W = 11,
    parameter int ALUOP_W  = 3,
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                reg2loc,
    output logic                aluSrc,
    output logic                memRd,
    output logic                memWr,
    output logic                memToReg,
    output logic                regWr,
    output logic [1:0]          seu,
    output logic [ALUOP_W-1:0]  aluOp,
    output logic                pcSrc,
    output logic                pcWr,
    output logic                irWr,
    output logic                illegal,
    output logic [2:0]          state,
    output logic [RETIRE_W-1:0] retired_cnt
);

    logic [2:0]          stateReg;
    logic [2:0]          stateNext;
    decoded_t            decNow;
    decoded_t            classReg;
    logic [RETIRE_W-1:0] retireReg;
    logic                retireEn;
    logic                takenCb;
    logic [2:0]          aluOpInt;

    mc_cu_decode #(
        .OPCODE_W(OPCODE_W)
    ) u_decode (
        .opcode(opcode),
        .dec   (decNow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg  <= ST_FETCH;
            classReg  <= '0;
            retireReg <= '0;
        end else begin
            stateReg <= stateNext;
            if (stateReg == ST_DECODE) begin
                classReg <= decNow;
            end
            if (retireEn) begin
                retireReg <= retireReg + RETIRE_W'(1);
            end
        end
    end

    always_comb begin
        stateNext = stateReg;
        retireEn  = 1'b0;
        reg2loc   = 1'b0;
        aluSrc    = 1'b0;
        memRd     = 1'b0;
        memWr     = 1'b0;
        memToReg  = 1'b0;
        regWr     = 1'b0;
        seu       = SEU_I;
        aluOpInt  = ALU_ADD;
        pcSrc     = 1'b0;
        pcWr      = 1'b0;
        irWr      = 1'b0;
        illegal   = 1'b0;
        takenCb   = (classReg.iClass == CL_CBZ) ? zero : !zero;

        case (stateReg)
            ST_FETCH: begin
                memRd = 1'b1;
                if (mem_ready) begin
                    irWr      = 1'b1;
                    pcWr      = 1'b1;
                    stateNext = ST_DECODE;
                end
            end
            ST_DECODE: begin
                stateNext = (decNow.iClass == CL_ILLEGAL) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                case (classReg.iClass)
                    CL_RTYPE: begin
                        aluOpInt  = classReg.aluOp;
                        stateNext = ST_WB;
                    end
                    CL_ITYPE: begin
                        aluSrc    = 1'b1;
                        seu       = SEU_I;
                        aluOpInt  = classReg.aluOp;
                        stateNext = ST_WB;
                    end
                    CL_LDUR, CL_STUR: begin
                        aluSrc    = 1'b1;
                        seu       = SEU_D;
                        aluOpInt  = ALU_ADD;
                        stateNext = ST_MEM;
                    end
                    CL_B: begin
                        seu       = SEU_B;
                        pcSrc     = 1'b1;
                        pcWr      = 1'b1;
                        retireEn  = 1'b1;
                        stateNext = ST_FETCH;
                    end
                    CL_CBZ, CL_CBNZ: begin
                        reg2loc   = 1'b1;
                        seu       = SEU_CB;
                        aluOpInt  = ALU_PASSB;
                        pcSrc     = takenCb;
                        pcWr      = takenCb;
                        retireEn  = 1'b1;
                        stateNext = ST_FETCH;
                    end
                    default: stateNext = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                memRd = (classReg.iClass == CL_LDUR);
                memWr = (classReg.iClass == CL_STUR);
                if (mem_ready) begin
                    if (classReg.iClass == CL_LDUR) begin
                        stateNext = ST_WB;
                    end else begin
                        retireEn  = 1'b1;
                        stateNext = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                regWr     = 1'b1;
                memToReg  = (classReg.iClass == CL_LDUR);
                retireEn  = 1'b1;
                stateNext = ST_FETCH;
            end
            ST_TRAP: begin
                illegal = 1'b1;
            end
            default: stateNext = ST_FETCH;
        endcase

        // Reset forces every strobe low immediately, not just at the next edge.
        if (!rst_n) begin
            retireEn = 1'b0;
            reg2loc  = 1'b0;
            aluSrc   = 1'b0;
            memRd    = 1'b0;
            memWr    = 1'b0;
            memToReg = 1'b0;
            regWr    = 1'b0;
            seu      = SEU_I;
            aluOpInt = ALU_ADD;
            pcSrc    = 1'b0;
            pcWr     = 1'b0;
            irWr     = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign aluOp       = ALUOP_W'(aluOpInt);
    assign state       = stateReg;
    assign retired_cnt = retireReg;

endmodule
